// File: rtl/vc_wrr_scheduler.sv
// Credit-based weighted round-robin pop scheduler between virtual channels vc0/vc1.
// Pops are decoded from state, so an asynchronous reset removes them immediately.
module vc_wrr_scheduler #(
  parameter int WEIGHT_W = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                enable,
  input  logic                fifo_empty_vc0,
  input  logic                fifo_empty_vc1,
  input  logic                dest_vc0,
  input  logic                dest_vc1,
  input  logic                fifo_pause_d0,
  input  logic                fifo_pause_d1,
  input  logic [WEIGHT_W-1:0] weight_vc0,
  input  logic [WEIGHT_W-1:0] weight_vc1,
  output logic                pop_vc0,
  output logic                pop_vc1,
  output logic                pop_delay_vc0,
  output logic                pop_delay_vc1,
  output logic [1:0]          state_o,
  output logic [CNT_W-1:0]    grant_cnt_vc0,
  output logic [CNT_W-1:0]    grant_cnt_vc1
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WEIGHT_W-1:0] r_credit;
  logic [WEIGHT_W-1:0] w_credit_nxt;
  logic                r_last;
  logic                r_pd0;
  logic                r_pd1;
  logic [CNT_W-1:0]    r_cnt0;
  logic [CNT_W-1:0]    r_cnt1;
  logic                w_elig0;
  logic                w_elig1;
  logic [WEIGHT_W-1:0] w_ew0;
  logic [WEIGHT_W-1:0] w_ew1;
  logic                w_pop0;
  logic                w_pop1;

  assign w_elig0 = ~fifo_empty_vc0 & ~(dest_vc0 ? fifo_pause_d1 : fifo_pause_d0);
  assign w_elig1 = ~fifo_empty_vc1 & ~(dest_vc1 ? fifo_pause_d1 : fifo_pause_d0);
  assign w_ew0   = (weight_vc0 == '0) ? WEIGHT_W'(1) : weight_vc0;
  assign w_ew1   = (weight_vc1 == '0) ? WEIGHT_W'(1) : weight_vc1;

  assign w_pop0  = enable & (r_state == SERVE0) & w_elig0;
  assign w_pop1  = enable & (r_state == SERVE1) & w_elig1;

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    case (r_state)
      IDLE: begin
        if (enable) begin
          if (w_elig0 && w_elig1) begin
            if (r_last) begin
              w_state_nxt  = SERVE0;
              w_credit_nxt = w_ew0;
            end else begin
              w_state_nxt  = SERVE1;
              w_credit_nxt = w_ew1;
            end
          end else if (w_elig0) begin
            w_state_nxt  = SERVE0;
            w_credit_nxt = w_ew0;
          end else if (w_elig1) begin
            w_state_nxt  = SERVE1;
            w_credit_nxt = w_ew1;
          end
        end
      end
      SERVE0: begin
        if (!enable) begin
          w_state_nxt  = IDLE;
          w_credit_nxt = '0;
        end else if (w_elig0 && (r_credit > WEIGHT_W'(1))) begin
          w_credit_nxt = r_credit - WEIGHT_W'(1);
        end else if (w_elig1) begin
          w_state_nxt  = SERVE1;
          w_credit_nxt = w_ew1;
        end else if (w_elig0) begin
          w_credit_nxt = w_ew0;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      SERVE1: begin
        if (!enable) begin
          w_state_nxt  = IDLE;
          w_credit_nxt = '0;
        end else if (w_elig1 && (r_credit > WEIGHT_W'(1))) begin
          w_credit_nxt = r_credit - WEIGHT_W'(1);
        end else if (w_elig0) begin
          w_state_nxt  = SERVE0;
          w_credit_nxt = w_ew0;
        end else if (w_elig1) begin
          w_credit_nxt = w_ew1;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_credit_nxt = '0;
      end
    endcase
  end

  // last_served starts at 1 so that vc0 wins the first tie after reset
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= IDLE;
      r_credit <= '0;
      r_last   <= 1'b1;
      r_pd0    <= 1'b0;
      r_pd1    <= 1'b0;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_pd0    <= w_pop0;
      r_pd1    <= w_pop1;
      if (w_pop0) begin
        r_last <= 1'b0;
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_pop1) begin
        r_last <= 1'b1;
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end
  end

  assign pop_vc0       = w_pop0;
  assign pop_vc1       = w_pop1;
  assign pop_delay_vc0 = r_pd0;
  assign pop_delay_vc1 = r_pd1;
  assign state_o       = r_state;
  assign grant_cnt_vc0 = r_cnt0;
  assign grant_cnt_vc1 = r_cnt1;

endmodule

// File: tb/tb_vc_wrr_scheduler.sv
// Bench for vc_wrr_scheduler: per-cycle reference model of turns and credits,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vc_wrr_scheduler;
  localparam int WEIGHT_W = 3;
  localparam int CNT_W    = 8;

  logic                clk = 1'b0;
  logic                reset_L = 1'b1;
  logic                enable = 1'b0;
  logic                fe0 = 1'b1, fe1 = 1'b1;
  logic                d0 = 1'b0, d1 = 1'b0;
  logic                p0 = 1'b0, p1 = 1'b0;
  logic [WEIGHT_W-1:0] w0 = '0, w1 = '0;
  logic                pop_vc0, pop_vc1, pop_delay_vc0, pop_delay_vc1;
  logic [1:0]          state_o;
  logic [CNT_W-1:0]    grant_cnt_vc0, grant_cnt_vc1;

  int errors = 0;
  int checks = 0;

  vc_wrr_scheduler #(.WEIGHT_W(WEIGHT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .fifo_empty_vc0(fe0), .fifo_empty_vc1(fe1),
    .dest_vc0(d0), .dest_vc1(d1),
    .fifo_pause_d0(p0), .fifo_pause_d1(p1),
    .weight_vc0(w0), .weight_vc1(w1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .pop_delay_vc0(pop_delay_vc0), .pop_delay_vc1(pop_delay_vc1),
    .state_o(state_o),
    .grant_cnt_vc0(grant_cnt_vc0), .grant_cnt_vc1(grant_cnt_vc1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner of the current turn (-1 none), pops left in the turn,
  // index of the last VC popped, grant totals and last cycle's pops.
  int m_own = -1;
  int m_rem = 0;
  int m_last = 1;
  int m_cnt[2] = '{0, 0};
  int m_pd[2]  = '{0, 0};

  always @(negedge clk) begin
    int el[2], ew[2], ep[2], pick, v, o;
    if (!reset_L) begin
      chk("rst_pop0", pop_vc0, 0);
      chk("rst_pop1", pop_vc1, 0);
      chk("rst_pd0", pop_delay_vc0, 0);
      chk("rst_pd1", pop_delay_vc1, 0);
      chk("rst_state", state_o, 0);
      chk("rst_cnt0", grant_cnt_vc0, 0);
      chk("rst_cnt1", grant_cnt_vc1, 0);
      m_own = -1; m_rem = 0; m_last = 1;
      m_cnt = '{0, 0}; m_pd = '{0, 0};
    end else begin
      el[0] = (!fe0 && !(d0 ? p1 : p0)) ? 1 : 0;
      el[1] = (!fe1 && !(d1 ? p1 : p0)) ? 1 : 0;
      ew[0] = (w0 == 0) ? 1 : int'(w0);
      ew[1] = (w1 == 0) ? 1 : int'(w1);
      for (int k = 0; k < 2; k++)
        ep[k] = (enable && m_own == k && el[k] != 0) ? 1 : 0;
      chk("pop0", pop_vc0, ep[0]);
      chk("pop1", pop_vc1, ep[1]);
      chk("pd0", pop_delay_vc0, m_pd[0]);
      chk("pd1", pop_delay_vc1, m_pd[1]);
      chk("state", state_o, m_own + 1);
      chk("cnt0", grant_cnt_vc0, m_cnt[0]);
      chk("cnt1", grant_cnt_vc1, m_cnt[1]);
      for (int k = 0; k < 2; k++) begin
        m_pd[k] = ep[k];
        if (ep[k] != 0) begin
          m_cnt[k] = (m_cnt[k] + 1) % (1 << CNT_W);
          m_last = k;
        end
      end
      if (m_own < 0) begin
        if (enable) begin
          if (el[0] != 0 && el[1] != 0) pick = 1 - m_last;
          else if (el[0] != 0)          pick = 0;
          else if (el[1] != 0)          pick = 1;
          else                          pick = -1;
          if (pick >= 0) begin
            m_own = pick;
            m_rem = ew[pick];
          end
        end
      end else begin
        v = m_own;
        o = 1 - v;
        if (!enable)                     m_own = -1;
        else if (el[v] != 0 && m_rem > 1) m_rem--;
        else if (el[o] != 0) begin m_own = o; m_rem = ew[o]; end
        else if (el[v] != 0)             m_rem = ew[v];
        else                             m_own = -1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    tick();
    reset_L = 1'b0;
    repeat (n) tick();
    reset_L = 1'b1;
  endtask

  task automatic wait_pop(input string name, input int which);
    int k = 0;
    @(negedge clk);
    while (((which != 0) ? pop_vc1 : pop_vc0) !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, (which != 0) ? pop_vc1 : pop_vc0, 1);
  endtask

  initial begin
    // 1/2: reset with both VCs ready, then the 3:1 pattern
    #1 reset_L = 1'b0;
    enable = 1'b1; fe0 = 1'b0; fe1 = 1'b0; d0 = 1'b0; d1 = 1'b0;
    p0 = 1'b0; p1 = 1'b0; w0 = 3'd3; w1 = 3'd1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_rst_pop0", pop_vc0, 0);
    end
    tick();
    reset_L = 1'b1;
    @(negedge clk);
    chk("t1_idle", state_o, 0);
    chk("t1_idle_pop0", pop_vc0, 0);
    @(negedge clk);
    chk("t1_serve0", state_o, 1);
    chk("t1_first_pop0", pop_vc0, 1);
    chk("t1_pd0_lag", pop_delay_vc0, 0);
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) chk("t1_pd0", pop_delay_vc0, 1);
      chk("t2_pat0", pop_vc0, (i % 4 != 3) ? 1 : 0);
      chk("t2_pat1", pop_vc1, (i % 4 == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("t2_cnt0", grant_cnt_vc0, 30);
    chk("t2_cnt1", grant_cnt_vc1, 10);

    // 3: zero weights alternate
    w0 = 3'd0; w1 = 3'd0;
    do_reset(2);
    wait_pop("t3_start", 0);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("t3_alt0", pop_vc0, (i % 2 == 0) ? 1 : 0);
      chk("t3_alt1", pop_vc1, (i % 2 == 1) ? 1 : 0);
    end

    // 4: pause on vc0's destination mid-turn
    w0 = 3'd3; w1 = 3'd1; fe0 = 1'b0; fe1 = 1'b1; d0 = 1'b1; d1 = 1'b0;
    do_reset(2);
    wait_pop("t4_start", 0);
    tick();
    p1 = 1'b1; fe1 = 1'b0;
    @(negedge clk);
    chk("t4_pause_pop0", pop_vc0, 0);
    chk("t4_pause_state", state_o, 1);
    tick();
    @(negedge clk);
    chk("t4_sw_state", state_o, 2);
    chk("t4_sw_pop1", pop_vc1, 1);
    tick();
    fe1 = 1'b1; p1 = 1'b0;
    @(negedge clk);
    chk("t4_back_pop0", pop_vc0, 0);
    chk("t4_back_pop1", pop_vc1, 0);
    @(negedge clk);
    chk("t4_resume_state", state_o, 1);
    chk("t4_resume_pop0", pop_vc0, 1);

    // 5: vc1 alone, weight 2, five words back-to-back
    fe0 = 1'b1; fe1 = 1'b0; d1 = 1'b0; w1 = 3'd2;
    do_reset(2);
    wait_pop("t5_start", 1);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk("t5_burst", pop_vc1, 1);
    end
    tick();
    fe1 = 1'b1;
    @(negedge clk);
    chk("t5_empty_pop1", pop_vc1, 0);
    chk("t5_cnt1", grant_cnt_vc1, 5);
    @(negedge clk);
    chk("t5_idle", state_o, 0);

    // 6: 255 vc0 pops, then reset in the middle of a vc1 turn
    fe0 = 1'b0; fe1 = 1'b1; d0 = 1'b0; w0 = 3'd7;
    do_reset(2);
    wait_pop("t6_start", 0);
    repeat (254) @(negedge clk);
    chk("t6_pop255", pop_vc0, 1);
    tick();
    fe0 = 1'b1; fe1 = 1'b0; d1 = 1'b0;
    @(negedge clk);
    chk("t6_cnt0_255", grant_cnt_vc0, 255);
    @(posedge clk);
    #3;
    chk("t6_serve1", state_o, 2);
    chk("t6_pop1_pre", pop_vc1, 1);
    reset_L = 1'b0;
    #1;
    chk("t6_async_pop1", pop_vc1, 0);
    chk("t6_async_state", state_o, 0);
    tick();
    fe0 = 1'b0;
    reset_L = 1'b1;
    @(negedge clk);
    chk("t6_idle", state_o, 0);
    @(negedge clk);
    chk("t6_vc0_first", state_o, 1);
    chk("t6_vc0_first_pop", pop_vc0, 1);

    // counter wrap on the 256th vc0 pop
    fe0 = 1'b0; fe1 = 1'b1;
    do_reset(2);
    wait_pop("t6w_start", 0);
    repeat (255) @(negedge clk);
    chk("t6w_pop256", pop_vc0, 1);
    chk("t6w_cnt255", grant_cnt_vc0, 255);
    @(negedge clk);
    chk("t6w_wrap", grant_cnt_vc0, 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset_L = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      enable  = ($urandom_range(0, 9) != 0);
      fe0     = ($urandom_range(0, 3) == 0);
      fe1     = ($urandom_range(0, 3) == 0);
      d0      = 1'($urandom_range(0, 1));
      d1      = 1'($urandom_range(0, 1));
      p0      = ($urandom_range(0, 4) == 0);
      p1      = ($urandom_range(0, 4) == 0);
      w0      = WEIGHT_W'($urandom_range(0, 7));
      w1      = WEIGHT_W'($urandom_range(0, 7));
    end
    tick();
    reset_L = 1'b1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
